// File: rtl/bus_access_multi_pkg.sv
// Shared cycle-type codes, default geometry and small decode helpers for the
// data-bus capture block.
package bus_access_multi_pkg;

  localparam logic [3:0] VIC_LP   = 4'd0;
  localparam logic [3:0] VIC_LPI2 = 4'd1;
  localparam logic [3:0] VIC_LS2  = 4'd2;
  localparam logic [3:0] VIC_LR   = 4'd3;
  localparam logic [3:0] VIC_LG   = 4'd4;
  localparam logic [3:0] VIC_HS1  = 4'd5;
  localparam logic [3:0] VIC_HPI1 = 4'd6;
  localparam logic [3:0] VIC_HPI2 = 4'd7;
  localparam logic [3:0] VIC_HS3  = 4'd8;
  localparam logic [3:0] VIC_HRI  = 4'd9;
  localparam logic [3:0] VIC_HRC  = 4'd10;
  localparam logic [3:0] VIC_HGC  = 4'd11;
  localparam logic [3:0] VIC_HGI  = 4'd12;
  localparam logic [3:0] VIC_HI   = 4'd13;
  localparam logic [3:0] VIC_LI   = 4'd14;
  localparam logic [3:0] VIC_HRX  = 4'd15;

  localparam int DEF_NUM_SPRITES     = 8;
  localparam int DEF_PTR_WIDTH       = 8;
  localparam int DEF_CHAR_WIDTH      = 12;
  localparam int DEF_LINE_CHARS      = 40;
  localparam int DEF_LINE_CHARS_WIDE = 80;
  localparam int DEF_BUF_DEPTH       = 128;

  localparam logic [DEF_PTR_WIDTH-1:0] ALL_ONES_PTR = '1;

  // Badline c-access: the character comes off the bus and refills the buffer.
  function automatic logic is_badline(input logic [3:0] ct);
    return (ct == VIC_HRC) || (ct == VIC_HGC);
  endfunction

  // Cache c-access: the character is replayed from the line buffer.
  function automatic logic is_cache(input logic [3:0] ct);
    return (ct == VIC_HRX) || (ct == VIC_HGI);
  endfunction

endpackage

// File: rtl/bus_access_multi_if.sv
// Bus-side signal bundle of the capture block: master drives the strobe and
// data bus, slave (the capture block) returns the captured values.
interface bus_access_multi_if
  import bus_access_multi_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int PTR_WIDTH   = DEF_PTR_WIDTH,
  parameter int CHAR_WIDTH  = DEF_CHAR_WIDTH,
  parameter int IDX_W       = $clog2(DEF_BUF_DEPTH)
);
  localparam int SC_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic                          phi_phase_start_dav;
  logic [3:0]                    cycle_type;
  logic [CHAR_WIDTH-1:0]         dbi;
  logic                          aec;
  logic                          idle;
  logic                          line_start;
  logic                          wide_mode;
  logic [SC_W-1:0]               sprite_cnt;
  logic [NUM_SPRITES-1:0]        sprite_dma;
  logic [NUM_SPRITES*PTR_WIDTH-1:0] sprite_ptr_o;
  logic [7:0]                    pixels_read;
  logic [CHAR_WIDTH-1:0]         char_read;
  logic [CHAR_WIDTH-1:0]         char_next;
  logic                          g_valid;
  logic                          p_valid;
  logic [IDX_W-1:0]              c_idx;

  modport master (
    output phi_phase_start_dav, cycle_type, dbi, aec, idle, line_start,
           wide_mode, sprite_cnt, sprite_dma,
    input  sprite_ptr_o, pixels_read, char_read, char_next, g_valid, p_valid, c_idx
  );

  modport slave (
    input  phi_phase_start_dav, cycle_type, dbi, aec, idle, line_start,
           wide_mode, sprite_cnt, sprite_dma,
    output sprite_ptr_o, pixels_read, char_read, char_next, g_valid, p_valid, c_idx
  );

endinterface

// File: rtl/bus_access_multi_char_line_buf.sv
// Single-port character line buffer: synchronous write, asynchronous read with
// write-first bypass so a same-cycle write is visible on rdata.
module char_line_buf #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = we ? wdata : mem[addr];

endmodule

// File: rtl/bus_access_multi.sv
// Data-bus capture for c-, g- and p-accesses with runtime line length,
// line-start index realignment and one-cycle valid strobes.
module bus_access_multi
  import bus_access_multi_pkg::*;
#(
  parameter int NUM_SPRITES     = DEF_NUM_SPRITES,
  parameter int PTR_WIDTH       = DEF_PTR_WIDTH,
  parameter int CHAR_WIDTH      = DEF_CHAR_WIDTH,
  parameter int LINE_CHARS      = DEF_LINE_CHARS,
  parameter int LINE_CHARS_WIDE = DEF_LINE_CHARS_WIDE,
  parameter int BUF_DEPTH       = DEF_BUF_DEPTH,
  parameter int IDX_W           = $clog2(BUF_DEPTH)
) (
  input logic               clk_dot4x,
  input logic               rst,
  bus_access_multi_if.slave bus
);

  localparam logic [IDX_W-1:0] LIM_NORM = IDX_W'(LINE_CHARS - 1);
  localparam logic [IDX_W-1:0] LIM_WIDE = IDX_W'(LINE_CHARS_WIDE - 1);

  logic [IDX_W-1:0]      c_idx_q;
  logic                  mode_q;
  logic [CHAR_WIDTH-1:0] char_next_q;
  logic [CHAR_WIDTH-1:0] char_read_q;
  logic [7:0]            pixels_q;
  logic                  g_valid_q;
  logic                  p_valid_q;
  logic [PTR_WIDTH-1:0]  ptr_q [NUM_SPRITES];

  logic                  dav;
  logic                  ls;
  logic                  bad;
  logic                  cache;
  logic                  mode_eff;
  logic                  g_hit;
  logic                  p_hit;
  logic                  buf_we;
  logic [IDX_W-1:0]      eidx;
  logic [IDX_W-1:0]      lim;
  logic [IDX_W-1:0]      idx_adv;
  logic [CHAR_WIDTH-1:0] entry;
  logic [CHAR_WIDTH-1:0] rd_data;

  assign dav   = bus.phi_phase_start_dav;
  assign ls    = dav && bus.line_start;
  assign bad   = is_badline(bus.cycle_type);
  assign cache = is_cache(bus.cycle_type);

  // A line start takes effect on the very strobe it qualifies, including its limit.
  assign eidx     = ls ? '0 : c_idx_q;
  assign mode_eff = ls ? bus.wide_mode : mode_q;
  assign lim      = mode_eff ? LIM_WIDE : LIM_NORM;
  // >= so an index stranded above a shortened limit still wraps.
  assign idx_adv  = (eidx >= lim) ? '0 : eidx + IDX_W'(1);

  assign entry  = {bus.dbi[CHAR_WIDTH-1:8], bus.aec ? 8'hFF : bus.dbi[7:0]};
  assign buf_we = !rst && dav && bad;

  assign g_hit = dav && !bus.aec && (bus.cycle_type == VIC_LG);
  assign p_hit = dav && !bus.aec && (bus.cycle_type == VIC_LP)
                 && (int'(bus.sprite_cnt) < NUM_SPRITES);

  char_line_buf #(
    .DEPTH  (BUF_DEPTH),
    .WIDTH  (CHAR_WIDTH),
    .ADDR_W (IDX_W)
  ) u_char_line_buf (
    .clk   (clk_dot4x),
    .we    (buf_we),
    .addr  (eidx),
    .wdata (entry),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      c_idx_q     <= '0;
      mode_q      <= 1'b0;
      char_next_q <= '0;
      char_read_q <= '0;
      pixels_q    <= '0;
      g_valid_q   <= 1'b0;
      p_valid_q   <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) ptr_q[i] <= '1;
    end else begin
      g_valid_q <= g_hit;
      p_valid_q <= p_hit;
      if (ls) mode_q <= bus.wide_mode;
      if (dav && (bad || cache)) begin
        c_idx_q     <= idx_adv;
        char_next_q <= bad ? entry : rd_data;
      end else if (ls) begin
        c_idx_q <= '0;
      end
      if (g_hit) begin
        pixels_q    <= bus.dbi[7:0];
        char_read_q <= bus.idle ? '0 : char_next_q;
      end
      if (p_hit) begin
        ptr_q[bus.sprite_cnt] <= bus.sprite_dma[bus.sprite_cnt]
                                 ? bus.dbi[PTR_WIDTH-1:0] : '1;
      end
    end
  end

  // Sprite 0 occupies the most significant slice of the flattened bus.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ptr_flat
    assign bus.sprite_ptr_o[(NUM_SPRITES-1-i)*PTR_WIDTH +: PTR_WIDTH] = ptr_q[i];
  end

  assign bus.c_idx       = c_idx_q;
  assign bus.char_next   = char_next_q;
  assign bus.char_read   = char_read_q;
  assign bus.pixels_read = pixels_q;
  assign bus.g_valid     = g_valid_q;
  assign bus.p_valid     = p_valid_q;

endmodule

// File: tb/tb_bus_access_multi.sv
// Bench for bus_access_multi: directed table, hand-written line sequences and a
// randomized run against a transaction-level reference model.
module tb_bus_access_multi;
  import bus_access_multi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_access_multi_if b ();

  bus_access_multi dut (
    .clk_dot4x (clk),
    .rst       (rst),
    .bus       (b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: one line buffer, a line position and the captured values.
  int         m_idx;
  bit         m_mode;
  logic [11:0] m_buf [128];
  logic [11:0] m_cn, m_cr;
  logic [7:0]  m_px;
  bit          m_gv, m_pv;
  logic [7:0]  m_ptr [8];

  typedef struct {
    logic        dav;
    logic [3:0]  ct;
    logic [11:0] dbi;
    logic        aec, idle, ls;
    logic [2:0]  sc;
    logic [7:0]  dma;
    logic [6:0]  e_idx;
    logic [11:0] e_cn, e_cr;
    logic [7:0]  e_px;
    logic        e_gv, e_pv;
    logic [63:0] e_ptr;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dav, input logic [3:0] ct, input logic [11:0] dbi,
                       input logic aec, input logic idle, input logic ls, input logic wm,
                       input logic [2:0] sc, input logic [7:0] dma);
    b.phi_phase_start_dav = dav;
    b.cycle_type = ct;
    b.dbi = dbi;
    b.aec = aec;
    b.idle = idle;
    b.line_start = ls;
    b.wide_mode = wm;
    b.sprite_cnt = sc;
    b.sprite_dma = dma;
  endtask

  task automatic model_apply();
    int e, len;
    bit c_hit;
    logic [11:0] ent;
    m_gv = 0;
    m_pv = 0;
    if (rst) begin
      m_idx = 0; m_mode = 0; m_cn = '0; m_cr = '0; m_px = '0;
      for (int i = 0; i < 8; i++) m_ptr[i] = ALL_ONES_PTR;
      return;
    end
    if (!b.phi_phase_start_dav) return;
    if (b.line_start) m_mode = b.wide_mode;
    e = b.line_start ? 0 : m_idx;
    len = m_mode ? 80 : 40;
    c_hit = 0;
    case (b.cycle_type)
      VIC_HRC, VIC_HGC: begin
        ent = b.aec ? {b.dbi[11:8], 8'hFF} : b.dbi;
        m_buf[e] = ent;
        m_cn = ent;
        c_hit = 1;
      end
      VIC_HRX, VIC_HGI: begin
        m_cn = m_buf[e];
        c_hit = 1;
      end
      VIC_LG: if (!b.aec) begin
        m_px = b.dbi[7:0];
        m_cr = b.idle ? 12'h000 : m_cn;
        m_gv = 1;
      end
      VIC_LP: if (!b.aec) begin
        m_ptr[b.sprite_cnt] = b.sprite_dma[b.sprite_cnt] ? b.dbi[7:0] : 8'hFF;
        m_pv = 1;
      end
      default: ;
    endcase
    if (c_hit) m_idx = (e + 1 >= len) ? 0 : e + 1;
    else if (b.line_start) m_idx = 0;
  endtask

  task automatic compare_model();
    logic [63:0] ep;
    for (int i = 0; i < 8; i++) ep[(7-i)*8 +: 8] = m_ptr[i];
    check("c_idx", 64'(b.c_idx), 64'(m_idx));
    check("char_next", 64'(b.char_next), 64'(m_cn));
    check("char_read", 64'(b.char_read), 64'(m_cr));
    check("pixels_read", 64'(b.pixels_read), 64'(m_px));
    check("g_valid", 64'(b.g_valid), 64'(m_gv));
    check("p_valid", 64'(b.p_valid), 64'(m_pv));
    check("sprite_ptr", b.sprite_ptr_o, ep);
  endtask

  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  localparam logic [63:0] ALLF = '1;
  localparam logic [63:0] P3   = 64'hFFFF_FF2D_FFFF_FFFF;
  localparam logic [63:0] P0   = 64'hABFF_FFFF_FFFF_FFFF;

  initial begin
    int r;
    logic [3:0] ct;

    //        dav ct       dbi      aec  idle ls   sc    dma    | idx  cn       cr       px     gv   pv   ptr
    tbl[0]  = '{1'b1, VIC_HGC, 12'hA34, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 7'd1, 12'hAFF, 12'h000, 8'h00, 1'b0, 1'b0, ALLF};
    tbl[1]  = '{1'b1, VIC_HRC, 12'h3C1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h000, 8'h00, 1'b0, 1'b0, ALLF};
    tbl[2]  = '{1'b1, VIC_LG,  12'h05A, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h3C1, 8'h5A, 1'b1, 1'b0, ALLF};
    tbl[3]  = '{1'b1, VIC_LG,  12'h0A5, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b1, 1'b0, ALLF};
    tbl[4]  = '{1'b1, VIC_LG,  12'h011, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b0, ALLF};
    tbl[5]  = '{1'b1, VIC_LP,  12'h02D, 1'b0, 1'b0, 1'b0, 3'd3, 8'h08, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b1, P3};
    tbl[6]  = '{1'b1, VIC_LP,  12'h02D, 1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b1, ALLF};
    tbl[7]  = '{1'b1, VIC_LP,  12'h077, 1'b1, 1'b0, 1'b0, 3'd3, 8'h08, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b0, ALLF};
    tbl[8]  = '{1'b0, VIC_LP,  12'h077, 1'b0, 1'b0, 1'b0, 3'd3, 8'h08, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b0, ALLF};
    tbl[9]  = '{1'b1, VIC_HRX, 12'h000, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 7'd1, 12'hAFF, 12'h000, 8'hA5, 1'b0, 1'b0, ALLF};
    tbl[10] = '{1'b1, VIC_HGI, 12'h000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h000, 8'hA5, 1'b0, 1'b0, ALLF};
    tbl[11] = '{1'b1, VIC_LG,  12'h0C3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 7'd2, 12'h3C1, 12'h3C1, 8'hC3, 1'b1, 1'b0, ALLF};
    tbl[12] = '{1'b1, VIC_LP,  12'h0AB, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 7'd2, 12'h3C1, 12'h3C1, 8'hC3, 1'b0, 1'b1, P0};

    // Reset held for two cycles while a strobe is presented.
    rst = 1'b1;
    drive(1'b1, VIC_HRC, 12'h123, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF);
    step();
    step();
    check("rst_ptr", b.sprite_ptr_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_c_idx", 64'(b.c_idx), 64'd0);
    check("rst_char_next", 64'(b.char_next), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].dav, tbl[i].ct, tbl[i].dbi, tbl[i].aec, tbl[i].idle, tbl[i].ls, 1'b0,
            tbl[i].sc, tbl[i].dma);
      step();
      check($sformatf("tbl%0d.c_idx", i), 64'(b.c_idx), 64'(tbl[i].e_idx));
      check($sformatf("tbl%0d.char_next", i), 64'(b.char_next), 64'(tbl[i].e_cn));
      check($sformatf("tbl%0d.char_read", i), 64'(b.char_read), 64'(tbl[i].e_cr));
      check($sformatf("tbl%0d.pixels_read", i), 64'(b.pixels_read), 64'(tbl[i].e_px));
      check($sformatf("tbl%0d.g_valid", i), 64'(b.g_valid), 64'(tbl[i].e_gv));
      check($sformatf("tbl%0d.p_valid", i), 64'(b.p_valid), 64'(tbl[i].e_pv));
      check($sformatf("tbl%0d.sprite_ptr", i), b.sprite_ptr_o, tbl[i].e_ptr);
    end

    // Normal badline line of 40, then a cache line replaying it.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, VIC_HRC, 12'(12'h500 + i), 1'b0, 1'b0, i == 0, 1'b0, 3'd0, 8'h00);
      step();
      if (i == 38) check("norm_idx39", 64'(b.c_idx), 64'd39);
      if (i == 39) check("norm_wrap", 64'(b.c_idx), 64'd0);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, VIC_HRX, 12'h000, 1'b0, 1'b0, i == 0, 1'b0, 3'd0, 8'h00);
      step();
      check($sformatf("reuse%0d", i), 64'(b.char_next), 64'(12'h500 + i));
    end

    // Wide line; dropping wide_mode mid-line must not move the wrap point.
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, VIC_HRC, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0,
            i == 0, i < 50, 3'd0, 8'h00);
      step();
      if (i == 39) check("wide_idx40", 64'(b.c_idx), 64'd40);
      if (i == 78) check("wide_idx79", 64'(b.c_idx), 64'd79);
      if (i == 79) check("wide_wrap", 64'(b.c_idx), 64'd0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: ct = VIC_HRC;
        1: ct = VIC_HGC;
        2, 3: ct = VIC_HRX;
        4: ct = VIC_HGI;
        5: ct = VIC_LG;
        6: ct = VIC_LP;
        default: ct = 4'($urandom_range(0, 15));
      endcase
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 7) != 0, ct, 12'($urandom_range(0, 4095)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
